// File: rtl/odbiornik_szeregowy.sv
// odbiornik_szeregowy: serial-in, parallel-out receive register.
// Reassembles n-bit words, LSB first, from the serial link. Framing comes
// from a start strobe and bit sampling from a per-bit enable. Each completed
// word is held on dane_wy with a one-cycle gotowe pulse. A new start during
// a frame aborts that frame and raises a one-cycle blad pulse.
module odbiornik_szeregowy #(
    parameter int n = 4
) (
    input  logic         zegar,
    input  logic         reset,
    input  logic         start,
    input  logic         takt,
    input  logic         swe,
    output logic [n-1:0] dane_wy,
    output logic         gotowe,
    output logic         zajety,
    output logic         blad
);

    localparam int CW = $clog2(n) + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ODBIOR = 1'b1
    } stan_t;

    stan_t           state_q, state_d;
    logic [n-1:0]    sr_q, sr_d;
    logic [CW-1:0]   licznik_q, licznik_d;
    logic [n-1:0]    dane_q, dane_d;
    logic            gotowe_q, gotowe_d;
    logic            blad_q, blad_d;

    logic            ostatni_bit;
    logic [n-1:0]    sr_przesun;
    logic [n-1:0]    sr_nowa_ramka;

    assign ostatni_bit   = (licznik_q == CW'(n - 1));
    assign sr_przesun    = {swe, sr_q[n-1:1]};
    assign sr_nowa_ramka = takt ? {swe, {(n-1){1'b0}}} : '0;

    // State and datapath registers; synchronous reset discards any partial word.
    always_ff @(posedge zegar) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            licznik_q <= '0;
            dane_q    <= '0;
            gotowe_q  <= 1'b0;
            blad_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            licznik_q <= licznik_d;
            dane_q    <= dane_d;
            gotowe_q  <= gotowe_d;
            blad_q    <= blad_d;
        end
    end

    // Next state: start opens or restarts a frame, the n-th sample closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ODBIOR;
                end
            end
            ODBIOR: begin
                if (!start && takt && ostatni_bit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and pulse outputs: shift on takt, publish the word on completion,
    // flag an abort when start arrives mid-frame.
    always_comb begin
        sr_d      = sr_q;
        licznik_d = licznik_q;
        dane_d    = dane_q;
        gotowe_d  = 1'b0;
        blad_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = sr_nowa_ramka;
                    licznik_d = takt ? CW'(1) : '0;
                end
            end
            ODBIOR: begin
                if (start) begin
                    blad_d    = 1'b1;
                    sr_d      = sr_nowa_ramka;
                    licznik_d = takt ? CW'(1) : '0;
                end else if (takt) begin
                    sr_d      = sr_przesun;
                    licznik_d = licznik_q + CW'(1);
                    if (ostatni_bit) begin
                        dane_d   = sr_przesun;
                        gotowe_d = 1'b1;
                    end
                end
            end
            default: begin
                sr_d      = '0;
                licznik_d = '0;
            end
        endcase
    end

    assign dane_wy = dane_q;
    assign gotowe  = gotowe_q;
    assign blad    = blad_q;
    assign zajety  = (state_q == ODBIOR);

endmodule

// File: tb/tb_odbiornik_szeregowy.sv
// tb_odbiornik_szeregowy: directed bench for odbiornik_szeregowy with n=4.
// Each step drives inputs for one clock edge and checks outputs #1 after it.
module tb_odbiornik_szeregowy;

    logic       zegar;
    logic       reset;
    logic       start;
    logic       takt;
    logic       swe;
    logic       swe_drv;
    logic       rt_mode;
    logic       tx_load;
    logic [3:0] tx_q = 4'b0000;
    logic [3:0] dane_wy;
    logic       gotowe;
    logic       zajety;
    logic       blad;

    int vectors     = 0;
    int miscompares = 0;
    int n_gotowe    = 0;
    int n_blad      = 0;
    int g0;
    int b0;

    odbiornik_szeregowy #(.n(4)) dut (
        .zegar   (zegar),
        .reset   (reset),
        .start   (start),
        .takt    (takt),
        .swe     (swe),
        .dane_wy (dane_wy),
        .gotowe  (gotowe),
        .zajety  (zajety),
        .blad    (blad)
    );

    // Free-running clock, 10 ns period.
    initial zegar = 1'b0;
    always #5 zegar = ~zegar;

    // Reference transmitter: parallel load of 4'b0110, otherwise shift right, LSB out.
    always @(posedge zegar) begin
        if (tx_load) tx_q <= 4'b0110;
        else         tx_q <= {1'b0, tx_q[3:1]};
    end

    assign swe = rt_mode ? tx_q[0] : swe_drv;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge zegar) begin
        if (gotowe === 1'b1) n_gotowe++;
        if (blad === 1'b1)   n_blad++;
    end

    task automatic apply_stimulus(input logic s, input logic t, input logic d);
        start   = s;
        takt    = t;
        swe_drv = d;
        @(posedge zegar);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [3:0] observed,
                                input logic [3:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        int gaps[4];
        logic [3:0] bits;
        gaps = '{3, 0, 1, 2};
        bits = 4'b1101;
        reset   = 1'b1;
        rt_mode = 1'b0;
        tx_load = 1'b0;

        // Reset held for two cycles
        apply_stimulus(0, 0, 0);
        apply_stimulus(0, 1, 1);
        check_output("reset_dane",   dane_wy, 4'b0000);
        check_output("reset_gotowe", {3'b0, gotowe}, 4'd0);
        check_output("reset_zajety", {3'b0, zajety}, 4'd0);
        check_output("reset_blad",   {3'b0, blad},   4'd0);
        reset = 1'b0;

        // Basic frame: bits 1,0,1,1 -> 4'b1101
        g0 = n_gotowe;
        apply_stimulus(1, 0, 0);
        check_output("basic_zajety_start", {3'b0, zajety}, 4'd1);
        apply_stimulus(0, 1, 1);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 1);
        check_output("basic_no_early_gotowe", {3'b0, gotowe}, 4'd0);
        check_output("basic_zajety_mid", {3'b0, zajety}, 4'd1);
        apply_stimulus(0, 1, 1);
        check_output("basic_dane",   dane_wy, 4'b1101);
        check_output("basic_gotowe", {3'b0, gotowe}, 4'd1);
        check_output("basic_zajety_end", {3'b0, zajety}, 4'd0);
        apply_stimulus(0, 0, 0);
        check_output("basic_gotowe_drop", {3'b0, gotowe}, 4'd0);
        check_output("basic_dane_held", dane_wy, 4'b1101);
        check_output("basic_gotowe_count", 4'(n_gotowe - g0), 4'd1);

        // Gapped bits after a clearing reset: gaps 3,0,1,2 before each bit
        reset = 1'b1;
        apply_stimulus(0, 0, 0);
        reset = 1'b0;
        check_output("gap_reset_dane", dane_wy, 4'b0000);
        g0 = n_gotowe;
        apply_stimulus(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            repeat (gaps[i]) apply_stimulus(0, 0, 1);
            apply_stimulus(0, 1, bits[i]);
        end
        check_output("gap_dane",   dane_wy, 4'b1101);
        check_output("gap_gotowe", {3'b0, gotowe}, 4'd1);
        apply_stimulus(0, 0, 0);
        apply_stimulus(0, 0, 0);
        check_output("gap_gotowe_count", 4'(n_gotowe - g0), 4'd1);

        // Abort: start, bits 1,1, start+takt with 0, then bits 1,0,1 -> 4'b1010
        g0 = n_gotowe;
        b0 = n_blad;
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 1, 1);
        apply_stimulus(0, 1, 1);
        apply_stimulus(1, 1, 0);
        check_output("abort_blad",   {3'b0, blad},   4'd1);
        check_output("abort_gotowe", {3'b0, gotowe}, 4'd0);
        check_output("abort_zajety", {3'b0, zajety}, 4'd1);
        check_output("abort_dane_kept", dane_wy, 4'b1101);
        apply_stimulus(0, 1, 1);
        check_output("abort_blad_drop", {3'b0, blad}, 4'd0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 1);
        check_output("abort_dane",   dane_wy, 4'b1010);
        check_output("abort_gotowe_end", {3'b0, gotowe}, 4'd1);
        apply_stimulus(0, 0, 0);
        check_output("abort_gotowe_count", 4'(n_gotowe - g0), 4'd1);
        check_output("abort_blad_count",   4'(n_blad - b0),   4'd1);

        // Start on the completing edge aborts; new frame bits 1,0,0,1 -> 4'b1001
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 1, 1);
        apply_stimulus(0, 1, 1);
        apply_stimulus(0, 1, 1);
        apply_stimulus(1, 1, 1);
        check_output("lastedge_blad",   {3'b0, blad},   4'd1);
        check_output("lastedge_gotowe", {3'b0, gotowe}, 4'd0);
        check_output("lastedge_dane",   dane_wy, 4'b1010);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 1);
        check_output("lastedge_new_dane", dane_wy, 4'b1001);
        check_output("lastedge_new_gotowe", {3'b0, gotowe}, 4'd1);

        // Back-to-back: start right after the completing edge, no blad
        apply_stimulus(1, 0, 0);
        check_output("b2b_blad",   {3'b0, blad},   4'd0);
        check_output("b2b_zajety", {3'b0, zajety}, 4'd1);
        repeat (4) apply_stimulus(0, 1, 1);
        check_output("b2b_dane", dane_wy, 4'b1111);
        apply_stimulus(0, 0, 0);

        // Reset mid-frame: start, 3 bits, reset -> everything cleared, no pulses
        g0 = n_gotowe;
        b0 = n_blad;
        apply_stimulus(1, 0, 0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 1);
        apply_stimulus(0, 1, 0);
        reset = 1'b1;
        apply_stimulus(0, 1, 1);
        reset = 1'b0;
        check_output("midrst_zajety", {3'b0, zajety}, 4'd0);
        check_output("midrst_dane",   dane_wy, 4'b0000);
        apply_stimulus(0, 0, 0);
        check_output("midrst_gotowe_count", 4'(n_gotowe - g0), 4'd0);
        check_output("midrst_blad_count",   4'(n_blad - b0),   4'd0);

        // takt in IDLE is ignored; start+takt samples bit 0: bits 1,0,0,0 -> 4'b0001
        apply_stimulus(0, 1, 1);
        apply_stimulus(0, 1, 1);
        check_output("idle_takt_zajety", {3'b0, zajety}, 4'd0);
        check_output("idle_takt_gotowe", {3'b0, gotowe}, 4'd0);
        apply_stimulus(1, 1, 1);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 0);
        check_output("starttakt_dane",   dane_wy, 4'b0001);
        check_output("starttakt_gotowe", {3'b0, gotowe}, 4'd1);
        apply_stimulus(0, 0, 0);

        // Round trip from the reference transmitter loaded with 4'b0110
        rt_mode = 1'b1;
        tx_load = 1'b1;
        apply_stimulus(1, 0, 0);
        tx_load = 1'b0;
        repeat (4) apply_stimulus(0, 1, 0);
        check_output("roundtrip_dane",   dane_wy, 4'b0110);
        check_output("roundtrip_gotowe", {3'b0, gotowe}, 4'd1);
        rt_mode = 1'b0;
        apply_stimulus(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
